acc_sequencer: RTL and testbench

ACC_SEQUENCER -- requirements
Module: acc_sequencer

---
 rtl/acc_sequencer.sv | 135 +++++++++++++
 tb/tb_acc_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_sequencer.sv
// Matrix-vector accelerator sequencer: streams a 4-vector and 4x4 matrix
// from memory on MVM, accumulates R[i] += M[i][j]*V[j]; DIC reads R back.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   instr_valid, instr       decode-stage instruction (opcode = instr[15:11])
//   rs_data                  MVM base address
//   stall, busy, done        pipeline hold, sequence active, completion pulse
//   mem_req, mem_addr        data-memory read request and address
//   mem_rdata, mem_ack       read data and transfer acknowledge
//   dic_data                 selected result element for DIC write-back
module acc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  input  logic [15:0] rs_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] dic_data
);

  localparam logic [4:0] OP_MVM = 5'b11111;
  localparam logic [4:0] OP_DIC = 5'b11110;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_V,
    LOAD_M
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] base_q;
  logic [4:0]  cnt_q;
  logic [15:0] v_q [4];
  logic [15:0] r_q [4];
  logic        rv_q;
  logic        done_q;

  logic        is_mvm;
  logic        is_dic;
  logic        accept;
  logic        last;
  logic        xfer;
  logic [3:0]  k;
  logic [15:0] prod;
  logic        unused_ok;

  assign is_mvm = instr_valid && (instr[15:11] == OP_MVM);
  assign is_dic = instr_valid && (instr[15:11] == OP_DIC);
  assign xfer   = mem_req && mem_ack;

  // Matrix element index; cnt 4..19 maps to k 0..15 modulo 16.
  assign k = cnt_q[3:0] - 4'd4;

  // Low half of a 16x16 product is identical for signed and unsigned.
  assign prod = mem_rdata * v_q[k[1:0]];

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b0;
    mem_req  = 1'b0;
    mem_addr = '0;
    accept   = 1'b0;
    last     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_mvm) begin
          accept  = 1'b1;
          state_d = LOAD_V;
        end
      end
      LOAD_V: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_q + {11'b0, cnt_q};
        if (mem_ack && cnt_q == 5'd3) state_d = LOAD_M;
      end
      LOAD_M: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = base_q + {11'b0, cnt_q};
        if (mem_ack && cnt_q == 5'd19) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      cnt_q  <= '0;
      v_q    <= '{default: '0};
      r_q    <= '{default: '0};
      rv_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        base_q <= rs_data;
        cnt_q  <= '0;
        r_q    <= '{default: '0};
        rv_q   <= 1'b0;
      end else if (xfer) begin
        cnt_q <= cnt_q + 5'd1;
        if (state_q == LOAD_V)
          v_q[cnt_q[1:0]] <= mem_rdata;
        else
          r_q[k[3:2]] <= r_q[k[3:2]] + prod;
        if (last) rv_q <= 1'b1;
      end
    end
  end

  assign done     = done_q;
  assign stall    = (is_mvm || is_dic) && busy;
  assign dic_data = (is_dic && !busy) ? r_q[instr[1:0]] : '0;

  // Only opcode and DIC index bits are decoded; results_valid is status only.
  assign unused_ok = ^{instr[10:2], rv_q};

endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer: queued addresses, done latencies
// and DIC results are checked by a negedge monitor.
module tb_acc_sequencer;

  localparam logic [4:0] OP_MVM = 5'b11111;
  localparam logic [4:0] OP_DIC = 5'b11110;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] rs_data;
  logic        stall;
  logic        busy;
  logic        done;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack = 1'b0;
  logic [15:0] dic_data;

  logic [15:0] mem [0:65535];
  logic [15:0] exp_addr [$];
  int          exp_lat [$];
  logic [15:0] exp_dic [$];

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   wait_n = 0;
  int   wcnt = 0;
  logic force_ack = 1'b0;
  bit   started = 1'b0;

  acc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instr      (instr),
    .rs_data    (rs_data),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .dic_data   (dic_data)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: wait_n idle cycles before each acknowledge.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (wcnt == wait_n) begin
        mem_ack = 1'b1;
        wcnt = 0;
      end else begin
        mem_ack = 1'b0;
        wcnt = wcnt + 1;
      end
    end else begin
      mem_ack = force_ack;
      wcnt = 0;
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] a;
    logic [15:0] d;
    int          l;
    if (started) begin
      if (mem_req && mem_ack) begin
        if (exp_addr.size() == 0) begin
          check("addr_unexpected", mem_addr, 16'hDEAD);
        end else begin
          a = exp_addr.pop_front();
          check("mem_addr", mem_addr, a);
        end
      end else if (mem_req && exp_addr.size() > 0) begin
        check("addr_hold", mem_addr, exp_addr[0]);
      end
      if (done) begin
        if (exp_lat.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          l = exp_lat.pop_front();
          check("done_latency", cyc - acc_cyc, l);
        end
      end
      if (instr_valid && instr[15:11] == OP_DIC) begin
        if (stall) begin
          check("dic_stalled_zero", dic_data, 0);
        end else if (exp_dic.size() == 0) begin
          check("dic_unexpected", dic_data, 16'hDEAD);
        end else begin
          d = exp_dic.pop_front();
          check("dic_data", dic_data, d);
        end
      end else begin
        check("dic_idle_zero", dic_data, 0);
      end
      if (instr_valid && instr[15:11] == OP_MVM && !busy && !rst)
        acc_cyc = cyc;
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [4:0] op, input logic [1:0] idx);
    instr = {op, 9'b0, idx};
    instr_valid = 1'b1;
  endtask

  task automatic idle_in;
    instr_valid = 1'b0;
    instr = '0;
  endtask

  task automatic push_mvm(input logic [15:0] b, input int n, input int lat);
    for (int i = 0; i < n; i++) exp_addr.push_back(b + 16'(i));
    if (lat > 0) exp_lat.push_back(lat);
  endtask

  task automatic start_mvm(input logic [15:0] b);
    step();
    rs_data = b;
    present(OP_MVM, 2'd0);
    step();
    idle_in();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("busy_timeout", busy, 0);
  endtask

  task automatic dic_read(input logic [1:0] idx, input logic [15:0] e);
    exp_dic.push_back(e);
    step();
    present(OP_DIC, idx);
    step();
    idle_in();
  endtask

  task automatic held(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check({name, "_stall_cycles"}, n, 16);
    check({name, "_release_done"}, done, 1);
    step();
    idle_in();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    for (int j = 0; j < 4; j++) mem[16'h0010 + j] = 16'(j + 1);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mem[16'h0014 + i * 4 + j] = (i == j) ? 16'd1 : 16'd0;
    mem[16'h0100] = 16'hFFFF;
    mem[16'h0101] = 16'd2;
    mem[16'h0104] = 16'd3;
    mem[16'h0105] = 16'h4000;
    mem[16'h0108] = 16'h8000;
    mem[16'h0109] = 16'h8000;
    mem[16'h010C] = 16'd5;
    mem[16'h010D] = 16'd7;
    for (int j = 0; j < 4; j++) mem[16'hFFF0 + j] = 16'd1;
    for (int j = 0; j < 12; j++) mem[16'hFFF4 + j] = 16'd2;
    for (int j = 0; j < 4; j++) mem[j] = 16'd3;

    rst = 1'b1;
    idle_in();
    rs_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_dic_data", dic_data, 0);
    rst = 1'b0;
    started = 1'b1;

    dic_read(2'd2, 16'h0000);

    force_ack = 1'b1;
    repeat (3) step();
    check("stray_ack_busy", busy, 0);
    check("stray_ack_req", mem_req, 0);
    force_ack = 1'b0;

    push_mvm(16'h0010, 20, 21);
    start_mvm(16'h0010);
    wait_idle(100);
    for (int i = 0; i < 4; i++) dic_read(2'(i), 16'(i + 1));

    push_mvm(16'h0100, 20, 21);
    start_mvm(16'h0100);
    wait_idle(100);
    dic_read(2'd0, 16'h7FFD);
    dic_read(2'd1, 16'h8000);
    dic_read(2'd2, 16'h0009);
    dic_read(2'd3, 16'h0000);

    wait_n = 2;
    push_mvm(16'h0010, 20, 61);
    start_mvm(16'h0010);
    wait_idle(200);
    wait_n = 0;
    for (int i = 0; i < 4; i++) dic_read(2'(i), 16'(i + 1));

    push_mvm(16'h0010, 20, 21);
    push_mvm(16'h0100, 20, 21);
    start_mvm(16'h0010);
    repeat (3) step();
    present(5'b00001, 2'd0);
    @(negedge clk);
    check("other_op_stall", stall, 0);
    check("other_op_busy", busy, 1);
    step();
    rs_data = 16'h0100;
    present(OP_MVM, 2'd0);
    held("mvm_held");
    wait_idle(100);
    dic_read(2'd0, 16'h7FFD);
    dic_read(2'd1, 16'h8000);

    push_mvm(16'h0010, 20, 21);
    start_mvm(16'h0010);
    repeat (4) step();
    exp_dic.push_back(16'd1);
    present(OP_DIC, 2'd0);
    held("dic_held");
    dic_read(2'd3, 16'd4);

    push_mvm(16'h0010, 11, 0);
    start_mvm(16'h0010);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_mem_req", mem_req, 0);
    check("abort_done", done, 0);
    repeat (3) step();
    for (int i = 0; i < 4; i++) dic_read(2'(i), 16'h0000);

    push_mvm(16'hFFF0, 20, 21);
    start_mvm(16'hFFF0);
    wait_idle(100);
    dic_read(2'd0, 16'd8);
    dic_read(2'd2, 16'd8);
    dic_read(2'd3, 16'd12);

    repeat (3) step();
    check("addr_queue_left", exp_addr.size(), 0);
    check("lat_queue_left", exp_lat.size(), 0);
    check("dic_queue_left", exp_dic.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
